// File: rtl/ysyx_23060208_ifu_if.sv
// Purpose: bundles the IFU's PC input, AXI4-Lite read channel and decode-side handshake.
// Latency: none, wires only.
// Backpressure: carries arready/rvalid from the bus and inst_ready from decode.
interface ysyx_23060208_ifu_if #(
    parameter int DATA_WIDTH = 32
);
    // PC register side
    logic [DATA_WIDTH-1:0] pc;
    logic                  fetch_req;

    // AXI4-Lite read address / read data channels
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    // Decode-stage handoff
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] inst_pc;
    logic                  inst_err;
    logic                  inst_valid;
    logic                  inst_ready;

    // IFU side of the bundle
    modport master (
        input  pc, fetch_req,
        input  arready, rdata, rresp, rvalid,
        input  inst_ready,
        output araddr, arvalid, rready,
        output inst, inst_pc, inst_err, inst_valid
    );

    // Environment side: PC register, memory slave and decode stage
    modport slave (
        output pc, fetch_req,
        output arready, rdata, rresp, rvalid,
        output inst_ready,
        input  araddr, arvalid, rready,
        input  inst, inst_pc, inst_err, inst_valid
    );
endinterface

// File: rtl/ysyx_23060208_ifu.sv
// Purpose: turns one fetch_req into one AXI4-Lite read of pc and hands the word to decode.
// Latency: fetch_req -> inst_valid is 3 cycles with a zero-wait slave, 1 cycle for a misaligned pc.
// Backpressure: holds inst/inst_pc/inst_err until inst_ready; one extra request is queued in pending.
module ysyx_23060208_ifu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_23060208_ifu_if.master          bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                state;
    logic                  pending;
    logic [DATA_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [DATA_WIDTH-1:0] inst_pc_q;
    logic                  inst_err_q;
    logic                  inst_valid_q;

    assign bus.araddr     = araddr_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.rready     = rready_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_err   = inst_err_q;
    assign bus.inst_valid = inst_valid_q;

    // Fetch FSM; handshake outputs are registered alongside the state so they
    // always match it and never see a combinational path from any input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_err_q   <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A queued request and a fresh one in the same cycle collapse into one fetch.
                    if (bus.fetch_req || pending) begin
                        araddr_q  <= bus.pc;
                        inst_pc_q <= bus.pc;
                        pending   <= 1'b0;
                        if (bus.pc[1:0] == 2'b00) begin
                            state     <= AR;
                            arvalid_q <= 1'b1;
                        end else begin
                            // Misaligned: report a fault without touching the bus.
                            state        <= HOLD;
                            inst_q       <= '0;
                            inst_err_q   <= 1'b1;
                            inst_valid_q <= 1'b1;
                        end
                    end
                end
                AR: begin
                    if (bus.fetch_req) begin
                        pending <= 1'b1;
                    end
                    // arvalid stays up with araddr frozen until the slave takes it.
                    if (bus.arready) begin
                        state     <= R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                R: begin
                    if (bus.fetch_req) begin
                        pending <= 1'b1;
                    end
                    // Data is kept even on an error response so decode can inspect it.
                    if (bus.rvalid) begin
                        state        <= HOLD;
                        rready_q     <= 1'b0;
                        inst_q       <= bus.rdata;
                        inst_err_q   <= (bus.rresp != 2'b00);
                        inst_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // A request on the handoff edge is queued and started from IDLE next cycle.
                    if (bus.fetch_req) begin
                        pending <= 1'b1;
                    end
                    if (bus.inst_ready) begin
                        state        <= IDLE;
                        inst_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_ifu.sv
// Purpose: directed checks of the IFU fetch FSM against hand-computed cycle timings.
// Latency: samples 1 ns after each rising edge; inputs change right after sampling.
// Backpressure: slave and decode handshakes are driven explicitly per step.
module tb_ysyx_23060208_ifu;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_23060208_ifu_if #(.DATA_WIDTH(32)) bus ();

    ysyx_23060208_ifu #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {arvalid, rready, inst_valid}
    function automatic logic [31:0] hs();
        return {29'd0, bus.arvalid, bus.rready, bus.inst_valid};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst            = 1'b0;
        bus.pc         = 32'h7FFF_FFFC;
        bus.fetch_req  = 1'b0;
        bus.arready    = 1'b0;
        bus.rdata      = 32'h0;
        bus.rresp      = 2'b00;
        bus.rvalid     = 1'b0;
        bus.inst_ready = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_hs",       hs(),         32'h0);
        chk("rst_araddr",   bus.araddr,   32'h0);
        chk("rst_inst",     bus.inst,     32'h0);
        chk("rst_inst_pc",  bus.inst_pc,  32'h0);
        chk("rst_inst_err", bus.inst_err, 32'h0);
        rst = 1'b1;
        step();
        chk("idle_hs", hs(), 32'h0);

        // Zero-wait fetch
        bus.pc = 32'h8000_0000; bus.fetch_req = 1'b1;
        bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0413; bus.inst_ready = 1'b1;
        step();
        bus.fetch_req = 1'b0;
        chk("zw_hs1",     hs(),       32'h4);
        chk("zw_araddr",  bus.araddr, 32'h8000_0000);
        step();
        chk("zw_hs2",     hs(),       32'h2);
        step();
        chk("zw_hs3",     hs(),       32'h1);
        chk("zw_inst",    bus.inst,    32'h0000_0413);
        chk("zw_inst_pc", bus.inst_pc, 32'h8000_0000);
        chk("zw_err",     bus.inst_err, 32'h0);
        step();
        chk("zw_hs4",     hs(),       32'h0);

        // Wait states: arready after 2 wait cycles, rvalid after 3
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.inst_ready = 1'b0;
        bus.pc = 32'h8000_0010; bus.fetch_req = 1'b1;
        step();
        bus.fetch_req = 1'b0;
        bus.pc = 32'h1234_5678;
        for (int i = 1; i <= 3; i++) begin
            chk("ws_ar_hs",     hs(),       32'h4);
            chk("ws_ar_araddr", bus.araddr, 32'h8000_0010);
            if (i == 3) bus.arready = 1'b1;
            step();
        end
        bus.arready = 1'b0;
        for (int i = 4; i <= 7; i++) begin
            chk("ws_r_hs", hs(), 32'h2);
            if (i == 7) begin
                bus.rvalid = 1'b1;
                bus.rdata  = 32'h0010_0093;
            end
            step();
        end
        bus.rvalid = 1'b0;
        chk("ws_hs8",     hs(),        32'h1);
        chk("ws_inst",    bus.inst,    32'h0010_0093);
        chk("ws_inst_pc", bus.inst_pc, 32'h8000_0010);
        bus.inst_ready = 1'b1;
        step();
        chk("ws_idle", hs(), 32'h0);

        // Error response
        bus.pc = 32'h8000_0020; bus.fetch_req = 1'b1;
        bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rresp = 2'b10; bus.rdata = 32'hDEAD_BEEF;
        bus.inst_ready = 1'b0;
        step();
        bus.fetch_req = 1'b0;
        step();
        step();
        chk("er_hs",   hs(),         32'h1);
        chk("er_err",  bus.inst_err, 32'h1);
        chk("er_inst", bus.inst,     32'hDEAD_BEEF);
        bus.inst_ready = 1'b1; bus.rresp = 2'b00;
        step();
        chk("er_idle", hs(), 32'h0);

        // Misaligned PC
        bus.pc = 32'h8000_0002; bus.fetch_req = 1'b1; bus.inst_ready = 1'b0;
        step();
        bus.fetch_req = 1'b0;
        chk("ma_hs",      hs(),         32'h1);
        chk("ma_inst",    bus.inst,     32'h0);
        chk("ma_err",     bus.inst_err, 32'h1);
        chk("ma_inst_pc", bus.inst_pc,  32'h8000_0002);
        bus.inst_ready = 1'b1;
        step();
        chk("ma_idle1", hs(), 32'h0);
        step();
        chk("ma_idle2", hs(), 32'h0);

        // Backpressure with two queued requests during HOLD
        bus.pc = 32'h8000_0030; bus.fetch_req = 1'b1; bus.rdata = 32'h1111_1111;
        bus.inst_ready = 1'b0;
        step();
        bus.fetch_req = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hs",      hs(),        32'h1);
            chk("bp_inst",    bus.inst,    32'h1111_1111);
            chk("bp_inst_pc", bus.inst_pc, 32'h8000_0030);
            bus.pc        = 32'h8000_0004;
            bus.fetch_req = (i == 1 || i == 3);
            step();
        end
        bus.fetch_req = 1'b0; bus.inst_ready = 1'b1; bus.rdata = 32'h2222_2222;
        step();
        chk("bp_idle", hs(), 32'h0);
        step();
        chk("bp_ar_hs",     hs(),       32'h4);
        chk("bp_ar_araddr", bus.araddr, 32'h8000_0004);
        step();
        step();
        chk("bp2_hs",      hs(),        32'h1);
        chk("bp2_inst",    bus.inst,    32'h2222_2222);
        chk("bp2_inst_pc", bus.inst_pc, 32'h8000_0004);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("bp_no_extra", hs(), 32'h0);
            step();
        end

        // Request on the handoff edge
        bus.pc = 32'h8000_0040; bus.fetch_req = 1'b1; bus.rdata = 32'h3333_3333;
        bus.inst_ready = 1'b0;
        step();
        bus.fetch_req = 1'b0;
        step();
        step();
        chk("ho_hold", hs(), 32'h1);
        bus.inst_ready = 1'b1; bus.fetch_req = 1'b1; bus.pc = 32'h8000_0044;
        step();
        bus.fetch_req = 1'b0;
        chk("ho_idle", hs(), 32'h0);
        step();
        chk("ho_ar_hs",     hs(),       32'h4);
        chk("ho_ar_araddr", bus.araddr, 32'h8000_0044);
        step();
        step();
        chk("ho_inst_pc", bus.inst_pc, 32'h8000_0044);
        chk("ho_inst",    bus.inst,    32'h3333_3333);
        step();
        chk("ho_done", hs(), 32'h0);

        // Reset asserted between edges while in AR
        bus.pc = 32'h8000_0050; bus.fetch_req = 1'b1; bus.arready = 1'b0;
        step();
        bus.fetch_req = 1'b0;
        chk("ra_pre", hs(), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        chk("ra_hs",     hs(),       32'h0);
        chk("ra_araddr", bus.araddr, 32'h0);
        step();
        rst = 1'b1;
        bus.arready = 1'b1;
        step();
        step();
        chk("ra_quiet", hs(), 32'h0);

        // Reset asserted between edges while in HOLD
        bus.pc = 32'h8000_0060; bus.fetch_req = 1'b1; bus.rvalid = 1'b1;
        bus.rdata = 32'h4444_4444; bus.inst_ready = 1'b0;
        step();
        bus.fetch_req = 1'b0;
        step();
        step();
        chk("rh_pre", hs(), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rh_hs",      hs(),        32'h0);
        chk("rh_inst",    bus.inst,    32'h0);
        chk("rh_inst_pc", bus.inst_pc, 32'h0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("rh_quiet", hs(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_ifu.md
# ysyx_23060208_ifu

Instruction fetch unit that reads the PC register value and turns it into one instruction-memory read over an AXI4-Lite read channel. It hands the fetched word to the decode stage over a valid/ready handshake. It sits between the PC register, the instruction memory/bus arbiter and the IDU. It issues exactly one fetch per `fetch_req` and never advances the PC itself; PC update stays with the PC register's `wen`/`next_pc` path.

## Interface
- `DATA_WIDTH`, 32: address and instruction width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc` in DATA_WIDTH: current PC register output.
- `fetch_req` in 1: one-cycle pulse meaning "PC register now holds the next fetch address". It is driven by the commit path one cycle after PC `wen`.
- `araddr` out DATA_WIDTH: read address, registered.
- `arvalid` out 1: read address valid.
- `arready` in 1: slave accepts the address.
- `rdata` in DATA_WIDTH: read data.
- `rresp` in 2: read response; 2'b00 is OKAY, anything else is a fault.
- `rvalid` in 1: read data valid.
- `rready` out 1: IFU accepts the read data.
- `inst` out DATA_WIDTH: fetched instruction, registered.
- `inst_pc` out DATA_WIDTH: address the instruction was fetched from.
- `inst_err` out 1: fault flag, either misaligned PC or a non-OKAY `rresp`.
- `inst_valid` out 1: `inst`/`inst_pc`/`inst_err` are valid.
- `inst_ready` in 1: IDU accepts the instruction.

## Operation
- There are four states: IDLE, AR, R, HOLD.
- **IDLE.** All handshake outputs are low.
  - On `fetch_req`, or with the pending flag set, the IFU latches `pc` into `araddr` and `inst_pc`, then clears pending.
  - If `pc[1:0]` is 0, it goes to AR.
  - Otherwise it goes directly to HOLD with `inst`=0 and `inst_err`=1; no bus transaction is issued.
- **AR.** `arvalid`=1 and `araddr` is held stable. On `arvalid && arready` the IFU goes to R. `arvalid` must never drop before the handshake completes.
- **R.** `rready`=1. On `rvalid` the IFU captures `inst`<=`rdata`, sets `inst_err`<=(`rresp`!=0), and goes to HOLD. The data is captured even on an error response.
- **HOLD.** `inst_valid`=1, and `inst`, `inst_pc` and `inst_err` are held stable. On `inst_ready` the IFU goes to IDLE.
- **Pending flag.**
  - A `fetch_req` seen in AR, R or HOLD sets the 1-bit pending flag.
  - A second request while pending is already set is absorbed, so at most one request is queued.
  - In IDLE, pending is treated exactly like `fetch_req`.
- **Simultaneous events.**
  - `fetch_req` in the same cycle as the HOLD→IDLE handshake sets pending, so the next fetch starts from IDLE one cycle later.
  - `fetch_req` in IDLE while pending is set produces one fetch only.
- There is no address arithmetic. `araddr` equals the latched `pc` bit-for-bit.

## Timing
- **Reset values.** State=IDLE, `arvalid`=0, `rready`=0, `inst_valid`=0, `araddr`=0, `inst`=0, `inst_pc`=0, `inst_err`=0, pending=0.
- **Reset mid-operation.** Asserting `rst` low at any time forces the reset values immediately, without waiting for a clock edge. An outstanding bus beat is abandoned, and the system reset also covers the slave.
- **Minimum latency with zero-wait slave.**
  - Cycle N: `fetch_req` in IDLE.
  - Cycle N+1: `arvalid` high, `arready`=1.
  - Cycle N+2: `rready` high, `rvalid`=1.
  - Cycle N+3: `inst_valid` high.
  - `fetch_req`→`inst_valid` is therefore 3 cycles.
- **Misaligned PC.** `inst_valid` is high at N+1.
- Each slave wait cycle on `arready` or `rvalid` adds exactly one cycle.
- Every output is a register or a pure decode of the state register. There is no combinational path from any input to any output.
- **Boot.** The PC register resets to 0x7FFF_FFFC. The first `fetch_req` comes after the first PC write, so the first `araddr` is 0x8000_0000.

## Test plan
- **Zero-wait fetch.** Reset, then pc=0x8000_0000, `fetch_req` pulse, `arready`=`rvalid`=1, `rdata`=0x00000413, `inst_ready`=1. Required: `araddr`=0x8000_0000 at +1, `inst_valid` at +3 with `inst`=0x00000413, `inst_pc`=0x8000_0000, `inst_err`=0, and back in IDLE at +4.
- **Wait states.** `arready` delayed 2 cycles and `rvalid` delayed 3 cycles. Required: `arvalid` and `araddr` stable throughout, `rready` high only in R, and `inst_valid` at +8.
- **Errors.**
  - `rresp`=2'b10 with `rdata`=0xDEADBEEF. Required: `inst_err`=1, `inst`=0xDEADBEEF.
  - pc=0x8000_0002. Required: no `arvalid`, `inst_valid` at +1, `inst`=0, `inst_err`=1.
- **Backpressure and queued request.** Hold `inst_ready`=0 for 5 cycles and pulse `fetch_req` twice during HOLD with pc=0x8000_0004. Required: outputs stable for all 5 cycles, then exactly one further fetch at 0x8000_0004.
- **Request on handoff edge.** Pulse `fetch_req` in the same cycle as `inst_valid && inst_ready`. Required: next `arvalid` rises 2 cycles later, and no request is lost.
- **Reset mid-operation.** Drive `rst` low between clock edges while in AR, and again while in HOLD. Required: `arvalid` and `inst_valid` fall immediately with no clock edge. After release the unit is idle, with no `arvalid` until the next `fetch_req`.
